// File: rtl/vc_test_mode_delay_source.sv
// vc_test_mode_delay_source: test source sending m[] with none/fixed/random/burst inter-message delays.
// Optional stall statistic enabled by defining VC_TEST_SRC_STALL_COUNT_EN.
module vc_test_mode_delay_source #(
  parameter int          p_msg_nbits = 8,
  parameter int          p_num_msgs  = 1024,
  parameter logic [15:0] p_seed      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [31:0]            max_delay,
  input  logic [31:0]            burst_len,
  input  logic [31:0]            num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [31:0]            stall_count
);
  localparam int AW = p_num_msgs > 1 ? $clog2(p_num_msgs) : 1;
  typedef enum logic [1:0] {SEND, DELAY, DONE} state_t;
  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];
  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d, dly_q, dly_d, bcnt_q, bcnt_d;
  logic [31:0] n, bl, bcnt_inc, rnd, d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        xfer, last, brst;
  assign n        = num_msgs > 32'(p_num_msgs) ? 32'(p_num_msgs) : num_msgs;
  assign val      = state_q == SEND && !reset;
  assign done     = state_q == DONE && !reset;
  assign msg      = m[idx_q[AW-1:0]];
  assign xfer     = val && rdy;
  assign last     = idx_q + 32'd1 >= n;
  assign bl       = burst_len == 32'd0 ? 32'd1 : burst_len;
  assign bcnt_inc = bcnt_q + 32'd1;
  assign brst     = bcnt_inc >= bl;
  // all-ones bound would overflow the modulus; every 16-bit value is already in range
  assign rnd      = &max_delay ? {16'd0, lfsr_q} : {16'd0, lfsr_q} % (max_delay + 32'd1);
  assign d        = mode == 2'd0 ? 32'd0 :
                    mode == 2'd1 ? max_delay :
                    mode == 2'd2 ? rnd : (brst ? max_delay : 32'd0);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    bcnt_d  = bcnt_q;
    lfsr_d  = lfsr_q;
    if (xfer) begin
      idx_d   = idx_q + 32'd1;
      state_d = last ? DONE : (d == 32'd0 ? SEND : DELAY);
      dly_d   = d == 32'd0 ? 32'd0 : d - 32'd1;
      lfsr_d  = mode == 2'd2 ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
      bcnt_d  = mode == 2'd3 ? (brst ? 32'd0 : bcnt_inc) : bcnt_q;
    end else if (state_q == DELAY) begin
      state_d = dly_q == 32'd0 ? SEND : DELAY;
      dly_d   = dly_q == 32'd0 ? 32'd0 : dly_q - 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= n != 32'd0 ? SEND : DONE;
      idx_q   <= '0;
      dly_q   <= '0;
      bcnt_q  <= '0;
      lfsr_q  <= p_seed;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      bcnt_q  <= bcnt_d;
      lfsr_q  <= lfsr_d;
    end
  end
`ifdef VC_TEST_SRC_STALL_COUNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else if (val && !rdy && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end
  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: doc/vc_test_mode_delay_source.md
VC_TEST_MODE_DELAY_SOURCE -- requirements
Module: vc_test_mode_delay_source

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 8, message width in bits.
REQ-002 SHALL have parameter p_num_msgs, default 1024, source memory depth in entries.
REQ-003 SHALL have parameter p_seed, default 16'hACE1, nonzero LFSR seed.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  input  2  delay mode: 0 none, 1 fixed, 2 random, 3 burst.
REQ-007 SHALL have port max_delay  input  32  delay bound (fixed value, random bound, or inter-burst gap).
REQ-008 SHALL have port burst_len  input  32  messages per burst in mode 3.
REQ-009 SHALL have port num_msgs  input  32  count of messages to send; values above p_num_msgs clamp to p_num_msgs.
REQ-010 SHALL have port val  output  1  message valid.
REQ-011 SHALL have port rdy  input  1  sink ready.
REQ-012 SHALL have port msg  output  p_msg_nbits  current message, m[index].
REQ-013 SHALL have port done  output  1  all num_msgs messages accepted.
REQ-014 SHALL have port stall_count  output  32  stall statistic (see Configuration).
REQ-015 SHALL hold messages in array m[0:p_num_msgs-1], written by the bench hierarchically before reset deasserts.

Function
REQ-016 SHALL implement states SEND, DELAY, DONE; val=1 only in SEND.
REQ-017 SHALL complete a transfer on a rising edge with val=1 and rdy=1, then increment index by one.
REQ-018 SHALL keep msg and val stable while val=1 and rdy=0.
REQ-019 SHALL enter SEND on the first cycle after reset deasserts if clamped num_msgs>0, otherwise DONE.
REQ-020 SHALL compute delay D at each transfer: mode 0 D=0; mode 1 D=max_delay; mode 2 D=lfsr % (max_delay+1); mode 3 D=max_delay when the transfer completes a burst, else D=0.
REQ-021 SHALL, after a transfer: go to DONE if index reaches num_msgs; else SEND next cycle if D=0; else DELAY with val=0 for exactly D cycles, then SEND.
REQ-022 SHALL use a 16-bit Fibonacci LFSR, taps 16,14,13,11, zero-extended to 32 bits for the modulo, advancing once per transfer, only in mode 2.
REQ-023 SHALL count transfers within a burst; the burst completes when the count reaches burst_len, then the count clears; burst_len=0 treated as 1.
REQ-024 SHALL sample mode, max_delay, burst_len only at transfer edges; changes at other times take effect at the next transfer.
REQ-025 SHALL assert done=1 and val=0 in DONE and hold there until reset, ignoring rdy.
REQ-026 SHALL use max_delay=0 in any mode to give back-to-back transfers.

Reset
REQ-027 SHALL on reset set index=0, state per REQ-019 afterwards, val=0, done=0, delay counter=0, burst count=0, lfsr=p_seed, stall_count=0.
REQ-028 SHALL, on reset asserted mid-operation (any state), discard progress and restart from m[0] after deassertion; m contents preserved.

Configuration
REQ-029 SHALL, with VC_TEST_SRC_STALL_COUNT_EN defined, increment stall_count each cycle val=1 and rdy=0, saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without VC_TEST_SRC_STALL_COUNT_EN, drive stall_count constant 0 with no counter logic; all other behaviour identical.

Verification
REQ-031 SHALL cover mode 0, rdy=1, num_msgs=4 -> val high cycles 0-3 after reset, m[0..3] in order, done at cycle 4.
REQ-032 SHALL cover mode 1, max_delay=2, rdy=1, num_msgs=3 -> transfers at cycles 0,3,6; done at cycle 7.
REQ-033 SHALL cover mode 3, burst_len=2, max_delay=3, rdy=1, num_msgs=4 -> transfers at cycles 0,1,5,6.
REQ-034 SHALL cover mode 2, max_delay=10, sink with random rdy, num_msgs=64 -> all messages in order, every gap <=10, zero sink failures, done within 5000 cycles.
REQ-035 SHALL cover rdy=0 for 5 cycles while val=1 -> msg unchanged, stall_count=5 with macro, 0 without.
REQ-036 SHALL cover reset asserted after 2 transfers -> next post-reset transfer carries m[0], done=0, stall_count=0.
